// File: rtl/mips_register_file_if.sv
// rtl/mips_register_file_if.sv - register file access bundle: one write port, two read ports, rs-zero flag
interface mips_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  reg_write;
    logic [ADDR_WIDTH-1:0] write_reg;
    logic [DATA_WIDTH-1:0] write_data;
    logic [ADDR_WIDTH-1:0] read_reg1;
    logic [ADDR_WIDTH-1:0] read_reg2;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;
    logic                  zero_src1;

    modport master (
        output reg_write, write_reg, write_data, read_reg1, read_reg2,
        input  read_data1, read_data2, zero_src1
    );

    modport slave (
        input  reg_write, write_reg, write_data, read_reg1, read_reg2,
        output read_data1, read_data2, zero_src1
    );
endinterface

// File: rtl/mips_register_file.sv
// rtl/mips_register_file.sv - 32x32 MIPS register file with hardwired $0, $sp reset value and optional write bypass
module mips_register_file #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter bit                    BYPASS     = 1'b1,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = 'h0000_3FFC
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_register_file_if.slave   rf
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int SP_IDX = 29;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wr_active;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    // Writes to $0 are dropped here so both storage and bypass see the same rule.
    assign wr_active = rf.reg_write && (rf.write_reg != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i[ADDR_WIDTH-1:0]] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (wr_active) begin
            regs[rf.write_reg] <= rf.write_data;
        end
    end

    always_comb begin
        rd1 = regs[rf.read_reg1];
        if (BYPASS && wr_active && (rf.read_reg1 == rf.write_reg)) begin
            rd1 = rf.write_data;
        end
        if (rf.read_reg1 == '0) begin
            rd1 = '0;
        end
    end

    always_comb begin
        rd2 = regs[rf.read_reg2];
        if (BYPASS && wr_active && (rf.read_reg2 == rf.write_reg)) begin
            rd2 = rf.write_data;
        end
        if (rf.read_reg2 == '0) begin
            rd2 = '0;
        end
    end

    assign rf.read_data1 = rd1;
    assign rf.read_data2 = rd2;
    assign rf.zero_src1  = ~|rd1;
endmodule

// File: tb/tb_mips_register_file.sv
// tb/tb_mips_register_file.sv - directed and scoreboard checks of mips_register_file with and without bypass
module tb_mips_register_file;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [31:0] mdl [32];
    logic        m_rst;
    logic        m_we;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;

    mips_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bif ();
    mips_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) nif ();

    mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) u_byp (
        .clk   (clk),
        .reset (reset),
        .rf    (bif)
    );

    mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) u_nobyp (
        .clk   (clk),
        .reset (reset),
        .rf    (nif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                         input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        reset = rst;
        m_rst = rst;
        m_we  = we;
        m_wr  = wr;
        m_wd  = wd;
        bif.reg_write = we;  nif.reg_write = we;
        bif.write_reg = wr;  nif.write_reg = wr;
        bif.write_data = wd; nif.write_data = wd;
        bif.read_reg1 = r1;  nif.read_reg1 = r1;
        bif.read_reg2 = r2;  nif.read_reg2 = r2;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit byp);
        if (idx == 5'd0) return 32'h0;
        if (byp && m_we && (m_wr != 5'd0) && (idx == m_wr)) return m_wd;
        return mdl[idx];
    endfunction

    // Model follows the same edge the DUTs see, using the inputs applied for that cycle.
    task automatic model_edge();
        @(posedge clk);
        if (m_rst) begin
            for (int k = 0; k < 32; k++) mdl[k] = (k == 29) ? 32'h0000_3FFC : 32'h0;
        end else if (m_we && (m_wr != 5'd0)) begin
            mdl[m_wr] = m_wd;
        end
    endtask

    initial begin
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  wr;
        logic        we;
        logic        rst;
        logic [31:0] wd;
        total = 0;
        bad   = 0;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);

        // Post-reset sweep
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            #1;
            check($sformatf("rst_b_rd1[%0d]", i), bif.read_data1, (i == 29) ? 32'h0000_3FFC : 32'h0);
            check($sformatf("rst_n_rd1[%0d]", i), nif.read_data1, (i == 29) ? 32'h0000_3FFC : 32'h0);
            check($sformatf("rst_b_z1[%0d]", i), {31'b0, bif.zero_src1}, (i == 29) ? 32'h0 : 32'h1);
            check($sformatf("rst_b_rd2[%0d]", 31 - i), bif.read_data2, (i == 2) ? 32'h0000_3FFC : 32'h0);
            @(negedge clk);
        end

        // Write $8, read back on both ports
        drive(1'b0, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd1, 5'd2);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
        #1;
        check("w8_b_rd1", bif.read_data1, 32'hDEAD_BEEF);
        check("w8_b_rd2", bif.read_data2, 32'hDEAD_BEEF);
        check("w8_n_rd1", nif.read_data1, 32'hDEAD_BEEF);
        check("w8_b_z1", {31'b0, bif.zero_src1}, 32'h0);
        @(negedge clk);

        // Write to $0 is ignored, including by bypass
        drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        #1;
        check("w0_b_rd1_pre", bif.read_data1, 32'h0);
        check("w0_b_rd2_pre", bif.read_data2, 32'h0);
        check("w0_b_z1_pre", {31'b0, bif.zero_src1}, 32'h1);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #1;
        check("w0_b_rd1_post", bif.read_data1, 32'h0);
        check("w0_n_rd2_post", nif.read_data2, 32'h0);
        @(negedge clk);

        // Same-cycle bypass on both ports vs. no bypass
        drive(1'b0, 1'b1, 5'd9, 32'h1234_5678, 5'd9, 5'd9);
        #1;
        check("byp_b_rd2_pre", bif.read_data2, 32'h1234_5678);
        check("byp_b_rd1_pre", bif.read_data1, 32'h1234_5678);
        check("byp_n_rd2_pre", nif.read_data2, 32'h0);
        check("byp_n_z1_pre", {31'b0, nif.zero_src1}, 32'h1);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        #1;
        check("byp_b_rd2_post", bif.read_data2, 32'h1234_5678);
        check("byp_n_rd2_post", nif.read_data2, 32'h1234_5678);
        @(negedge clk);

        // Reset dominates a simultaneous write
        drive(1'b0, 1'b1, 5'd10, 32'hA5A5_A5A5, 5'd10, 5'd29);
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd10, 32'h5A5A_5A5A, 5'd10, 5'd29);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd29);
        #1;
        check("rw_b_rd1", bif.read_data1, 32'h0);
        check("rw_b_rd2", bif.read_data2, 32'h0000_3FFC);
        check("rw_n_rd1", nif.read_data1, 32'h0);
        check("rw_n_rd2", nif.read_data2, 32'h0000_3FFC);
        check("rw_b_z1", {31'b0, bif.zero_src1}, 32'h1);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9);
        #1;
        check("rw_b_rd8", bif.read_data1, 32'h0);
        check("rw_b_rd9", bif.read_data2, 32'h0);

        // Random stream against the scoreboard, starting from a known reset
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        model_edge();
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 63) == 0);
            we  = 1'($urandom_range(0, 1));
            wr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            wd  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            r1  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
            drive(rst, we, wr, wd, r1, r2);
            #1;
            check("rnd_b_rd1", bif.read_data1, exp_read(r1, 1'b1));
            check("rnd_b_rd2", bif.read_data2, exp_read(r2, 1'b1));
            check("rnd_b_z1", {31'b0, bif.zero_src1}, {31'b0, exp_read(r1, 1'b1) == 32'h0});
            check("rnd_n_rd1", nif.read_data1, exp_read(r1, 1'b0));
            check("rnd_n_rd2", nif.read_data2, exp_read(r2, 1'b0));
            check("rnd_n_z1", {31'b0, nif.zero_src1}, {31'b0, exp_read(r1, 1'b0) == 32'h0});
            model_edge();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
